// File: rtl/text_blink_overlay.sv
// Text-mode blink/cursor overlay: 2-cycle fixed latency, one pixel per cycle, never stalls.
// Define CURSOR_BLOCK_EN to honour cursor_block (inverse-video block cursor); otherwise underline only.
module text_blink_overlay #(
  parameter int COLOR_W         = 4,
  parameter int COL_W           = 7,
  parameter int ROW_W           = 5,
  parameter int LINE_W          = 4,
  parameter int UNDERLINE_FIRST = 14
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               blinking,
  input  logic               frame_start,
  input  logic               pix_valid,
  input  logic               pix_on,
  input  logic               pix_blink,
  input  logic [COLOR_W-1:0] pix_fg,
  input  logic [COLOR_W-1:0] pix_bg,
  input  logic [COL_W-1:0]   pix_col,
  input  logic [ROW_W-1:0]   pix_row,
  input  logic [LINE_W-1:0]  pix_line,
  input  logic               cursor_en,
  input  logic [COL_W-1:0]   cursor_col,
  input  logic [ROW_W-1:0]   cursor_row,
  input  logic               cursor_block,
  output logic               out_valid,
  output logic [COLOR_W-1:0] out_color
);

  logic cur_vis;
  logic txt_vis;

  // Phases only move at frame_start so a frame never tears; text toggles on cursor rising phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_vis <= 1'b1;
      txt_vis <= 1'b1;
    end else if (frame_start) begin
      cur_vis <= blinking;
      if (blinking && !cur_vis)
        txt_vis <= ~txt_vis;
    end
  end

  logic glyph;
  logic pos_match;
  logic underline;
  logic in_shape;

  always_comb begin
    glyph     = pix_on & (~pix_blink | txt_vis);
    pos_match = (pix_col == cursor_col) && (pix_row == cursor_row);
    underline = pix_line >= LINE_W'(UNDERLINE_FIRST);
`ifdef CURSOR_BLOCK_EN
    in_shape  = cursor_block | underline;
`else
    in_shape  = underline;
`endif
  end

`ifndef CURSOR_BLOCK_EN
  logic unused_cursor_block;
  assign unused_cursor_block = cursor_block;
`endif

  logic               s1_valid;
  logic               s1_glyph;
  logic               s1_hit;
  logic               s1_block;
  logic [COLOR_W-1:0] s1_fg;
  logic [COLOR_W-1:0] s1_bg;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_glyph <= 1'b0;
      s1_hit   <= 1'b0;
      s1_block <= 1'b0;
      s1_fg    <= '0;
      s1_bg    <= '0;
    end else begin
      s1_valid <= pix_valid;
      s1_glyph <= glyph;
      s1_hit   <= cursor_en & cur_vis & pos_match & in_shape;
`ifdef CURSOR_BLOCK_EN
      s1_block <= cursor_block;
`else
      s1_block <= 1'b0;
`endif
      s1_fg    <= pix_fg;
      s1_bg    <= pix_bg;
    end
  end

  logic [COLOR_W-1:0] cursor_color;
  logic [COLOR_W-1:0] next_color;

  always_comb begin
    cursor_color = s1_fg;
    if (s1_block)
      cursor_color = s1_glyph ? s1_bg : s1_fg;
    if (!s1_valid)
      next_color = '0;
    else if (s1_hit)
      next_color = cursor_color;
    else if (s1_glyph)
      next_color = s1_fg;
    else
      next_color = s1_bg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_color <= '0;
    end else begin
      out_valid <= s1_valid;
      out_color <= next_color;
    end
  end

endmodule

// File: tb/tb_text_blink_overlay.sv
// Directed bench for text_blink_overlay: reset, blink phases, cursor shape/position, frame overlap.
module tb_text_blink_overlay;

  logic       clk = 1'b0;
  logic       reset;
  logic       blinking;
  logic       frame_start;
  logic       pix_valid;
  logic       pix_on;
  logic       pix_blink;
  logic [3:0] pix_fg;
  logic [3:0] pix_bg;
  logic [6:0] pix_col;
  logic [4:0] pix_row;
  logic [3:0] pix_line;
  logic       cursor_en;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;
  logic       cursor_block;
  logic       out_valid;
  logic [3:0] out_color;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  text_blink_overlay dut (
    .clk(clk), .reset(reset), .blinking(blinking), .frame_start(frame_start),
    .pix_valid(pix_valid), .pix_on(pix_on), .pix_blink(pix_blink),
    .pix_fg(pix_fg), .pix_bg(pix_bg), .pix_col(pix_col), .pix_row(pix_row),
    .pix_line(pix_line), .cursor_en(cursor_en), .cursor_col(cursor_col),
    .cursor_row(cursor_row), .cursor_block(cursor_block),
    .out_valid(out_valid), .out_color(out_color)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pix_valid = 1'b0;
    frame_start = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic do_frame(input logic b);
    blinking = b;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // One valid pixel for one cycle; returns the output two edges later.
  task automatic run_pixel(output logic v, output logic [3:0] c);
    pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    frame_start = 1'b0;
    tick();
    v = out_valid;
    c = out_color;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pix_valid = 1'b1;
    pix_on = 1'b1;
    pix_blink = 1'b0;
    pix_fg = 4'hF;
    pix_bg = 4'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || out_color !== 4'h0) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: valid=%b color=%h, want valid=0 color=0", i, out_valid, out_color);
      end
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_plus1: valid=%b, want 0", out_valid);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_color !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_release_plus2: valid=%b color=%h, want valid=1 color=f", out_valid, out_color);
    end
    pix_valid = 1'b0;
    tick();
  endtask

  task automatic test_blink();
    logic [3:0] pat;
    logic [3:0] exp_col [4];
    logic       v;
    logic [3:0] c;
    pat = 4'b1010;  // bit i = blinking at frame i: 0,1,0,1
    exp_col[0] = 4'hF; exp_col[1] = 4'h1; exp_col[2] = 4'h1; exp_col[3] = 4'hF;
    do_reset();
    cursor_en = 1'b0;
    pix_on = 1'b1;
    pix_blink = 1'b1;
    pix_fg = 4'hF;
    pix_bg = 4'h1;
    for (int i = 0; i < 4; i++) begin
      do_frame(pat[i]);
      run_pixel(v, c);
      n_checks++;
      if (v !== 1'b1 || c !== exp_col[i]) begin
        n_fail++;
        $display("FAIL blink_attr[%0d]: valid=%b color=%h, want valid=1 color=%h", i, v, c, exp_col[i]);
      end
    end
    pix_blink = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_frame(pat[i]);
      run_pixel(v, c);
      n_checks++;
      if (v !== 1'b1 || c !== 4'hF) begin
        n_fail++;
        $display("FAIL no_blink_attr[%0d]: valid=%b color=%h, want valid=1 color=f", i, v, c);
      end
    end
  endtask

  task automatic test_cursor();
    logic [3:0] lines [6];
    logic [6:0] cols  [6];
    logic [4:0] rows  [6];
    logic [3:0] exp_c [6];
    logic       v;
    logic [3:0] c;
    lines[0] = 4'd14; cols[0] = 7'd5; rows[0] = 5'd3; exp_c[0] = 4'hA;
    lines[1] = 4'd15; cols[1] = 7'd5; rows[1] = 5'd3; exp_c[1] = 4'hA;
    lines[2] = 4'd13; cols[2] = 7'd5; rows[2] = 5'd3; exp_c[2] = 4'h0;
    lines[3] = 4'd14; cols[3] = 7'd6; rows[3] = 5'd3; exp_c[3] = 4'h0;
    lines[4] = 4'd14; cols[4] = 7'd5; rows[4] = 5'd4; exp_c[4] = 4'h0;
    lines[5] = 4'd0;  cols[5] = 7'd5; rows[5] = 5'd3; exp_c[5] = 4'h0;
    do_reset();
    cursor_en = 1'b1;
    cursor_block = 1'b0;
    cursor_col = 7'd5;
    cursor_row = 5'd3;
    pix_on = 1'b0;
    pix_blink = 1'b0;
    pix_fg = 4'hA;
    pix_bg = 4'h0;
    for (int i = 0; i < 6; i++) begin
      pix_line = lines[i];
      pix_col = cols[i];
      pix_row = rows[i];
      run_pixel(v, c);
      n_checks++;
      if (c !== exp_c[i]) begin
        n_fail++;
        $display("FAIL cursor_pos[%0d]: color=%h, want %h", i, c, exp_c[i]);
      end
    end
    pix_line = 4'd14;
    pix_col = 7'd5;
    pix_row = 5'd3;
    cursor_en = 1'b0;
    run_pixel(v, c);
    n_checks++;
    if (c !== 4'h0) begin
      n_fail++;
      $display("FAIL cursor_disabled: color=%h, want 0", c);
    end
    cursor_en = 1'b1;
    do_frame(1'b0);
    run_pixel(v, c);
    n_checks++;
    if (c !== 4'h0) begin
      n_fail++;
      $display("FAIL cursor_off_phase: color=%h, want 0", c);
    end
    do_frame(1'b1);
    run_pixel(v, c);
    n_checks++;
    if (c !== 4'hA) begin
      n_fail++;
      $display("FAIL cursor_on_phase: color=%h, want a", c);
    end
  endtask

  task automatic test_block();
    logic       v;
    logic [3:0] c;
    logic [3:0] exp_on;
    logic [3:0] exp_off;
`ifdef CURSOR_BLOCK_EN
    exp_on = 4'h2; exp_off = 4'hA;
`else
    exp_on = 4'hA; exp_off = 4'h2;
`endif
    do_reset();
    cursor_en = 1'b1;
    cursor_block = 1'b1;
    cursor_col = 7'd5;
    cursor_row = 5'd3;
    pix_col = 7'd5;
    pix_row = 5'd3;
    pix_line = 4'd2;
    pix_blink = 1'b0;
    pix_fg = 4'hA;
    pix_bg = 4'h2;
    pix_on = 1'b1;
    run_pixel(v, c);
    n_checks++;
    if (c !== exp_on) begin
      n_fail++;
      $display("FAIL block_glyph_on: color=%h, want %h", c, exp_on);
    end
    pix_on = 1'b0;
    run_pixel(v, c);
    n_checks++;
    if (c !== exp_off) begin
      n_fail++;
      $display("FAIL block_glyph_off: color=%h, want %h", c, exp_off);
    end
    cursor_block = 1'b0;
    run_pixel(v, c);
    n_checks++;
    if (c !== 4'h2) begin
      n_fail++;
      $display("FAIL underline_mode_line2: color=%h, want 2", c);
    end
  endtask

  task automatic test_valid_low();
    do_reset();
    cursor_en = 1'b0;
    pix_on = 1'b1;
    pix_fg = 4'hF;
    pix_bg = 4'hF;
    pix_valid = 1'b0;
    tick();
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || out_color !== 4'h0) begin
      n_fail++;
      $display("FAIL valid_low: valid=%b color=%h, want valid=0 color=0", out_valid, out_color);
    end
  endtask

  task automatic test_frame_overlap();
    logic       v;
    logic [3:0] c;
    do_reset();
    cursor_en = 1'b1;
    cursor_block = 1'b0;
    cursor_col = 7'd5;
    cursor_row = 5'd3;
    pix_col = 7'd5;
    pix_row = 5'd3;
    pix_line = 4'd14;
    pix_on = 1'b0;
    pix_blink = 1'b0;
    pix_fg = 4'hA;
    pix_bg = 4'h0;
    blinking = 1'b0;
    frame_start = 1'b1;
    run_pixel(v, c);
    n_checks++;
    if (v !== 1'b1 || c !== 4'hA) begin
      n_fail++;
      $display("FAIL overlap_same_cycle: valid=%b color=%h, want valid=1 color=a", v, c);
    end
    run_pixel(v, c);
    n_checks++;
    if (c !== 4'h0) begin
      n_fail++;
      $display("FAIL overlap_next_pixel: color=%h, want 0", c);
    end
  endtask

  initial begin
    reset = 1'b1;
    blinking = 1'b1;
    frame_start = 1'b0;
    pix_valid = 1'b0;
    pix_on = 1'b0;
    pix_blink = 1'b0;
    pix_fg = '0;
    pix_bg = '0;
    pix_col = '0;
    pix_row = '0;
    pix_line = '0;
    cursor_en = 1'b0;
    cursor_col = 7'd5;
    cursor_row = 5'd3;
    cursor_block = 1'b0;
    test_reset();
    test_blink();
    test_cursor();
    test_block();
    test_valid_low();
    test_frame_overlap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
